// File: rtl/serial_priority_encoder.sv
// Serial priority encoder: captures a multi-hot request vector and emits the index of each set bit,
// lowest first, one per valid/ready handshake. Define SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN to add the 'none' output.
module serial_priority_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Enable,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic         code_last,
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
  output logic         none,
`endif
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  localparam logic [N-1:0] One = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         single_bit;

`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
  logic none_q, none_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
      none_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
      none_q    <= none_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    req_ready = 1'b0;
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
    none_d    = none_q;
`endif
    unique case (state_q)
      StIdle: begin
        req_ready = Enable;
        if (req_valid && Enable) begin
          if (req != '0) begin
            pending_d = req;
            state_d   = StEmit;
          end
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
          else begin
            none_d  = 1'b1;
            state_d = StEmit;
          end
`endif
        end
      end
      StEmit: begin
        if (code_ready) begin
          // x & (x - 1) clears the lowest set bit, i.e. the one just transferred
          pending_d = pending_q & (pending_q - One);
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
          none_d    = 1'b0;
`endif
          if (pending_d == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on registered state, never on req.
  always_comb begin
    code = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pending_q[i]) code = W'(i);
    end
  end

  assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - One)) == '0);
  assign code_valid = (state_q == StEmit);
  assign busy       = (state_q == StEmit);

`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
  assign none      = code_valid && none_q;
  assign code_last = code_valid && (single_bit || none_q);
`else
  assign code_last = code_valid && single_bit;
`endif

endmodule

// File: tb/tb_serial_priority_encoder.sv
// Self-checking bench for serial_priority_encoder: directed scenarios plus random vectors and
// random backpressure, checked against a per-vector queue of expected codes.
module tb_serial_priority_encoder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         Enable;
  logic [N-1:0] req;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] code;
  logic         code_valid;
  logic         code_ready;
  logic         code_last;
  logic         busy;
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
  logic         none;
`endif

  int checks = 0;
  int passed = 0;

  serial_priority_encoder #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Enable     (Enable),
    .req        (req),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_last  (code_last),
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
    .none       (none),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for a single accepting edge.
  task automatic send(input logic [N-1:0] vec);
    check("req_ready_before_send", req_ready, 1);
    req_valid = 1'b1;
    req       = vec;
    step();
    req_valid = 1'b0;
  endtask

  // Expected emission order is simply the set bits in ascending index order.
  task automatic drain(input logic [N-1:0] vec, input int first_stall, input bit rnd,
                       input bit noise);
    int q[$];
    int stalls;
    for (int i = 0; i < int'(N); i++) if (vec[i]) q.push_back(i);
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
    if (vec == '0) q.push_back(0);
`endif
    stalls = 0;
    while (q.size() > 0) begin
      check("code_valid", code_valid, 1);
      check("code", code, q[0]);
      check("code_last", code_last, (q.size() == 1) ? 1 : 0);
      check("busy", busy, 1);
      check("req_ready_emit", req_ready, 0);
`ifdef SERIAL_PRIORITY_ENCODER_NONE_FLAG_EN
      check("none", none, (vec == '0) ? 1 : 0);
`endif
      if (noise) begin
        req_valid = 1'b1;
        req       = 4'b0001;
      end
      if (first_stall > 0) begin
        code_ready = 1'b0;
        first_stall--;
      end else if (rnd && stalls < 3 && $urandom_range(0, 2) == 0) begin
        code_ready = 1'b0;
        stalls++;
      end else begin
        code_ready = 1'b1;
        stalls = 0;
      end
      step();
      if (code_ready) void'(q.pop_front());
    end
    req_valid  = 1'b0;
    code_ready = 1'b0;
    check("idle_code_valid", code_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_code_last", code_last, 0);
    check("idle_req_ready", req_ready, {31'b0, Enable});
  endtask

  initial begin
    logic [N-1:0] v;
    rst_n      = 1'b1;
    Enable     = 1'b1;
    req        = '0;
    req_valid  = 1'b0;
    code_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_code_valid", code_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_code", code, 0);
    check("rst_code_last", code_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_req_ready", req_ready, 1);

    // Basic ordering with code_ready held high
    send(4'b1011);
    drain(4'b1011, 0, 1'b0, 1'b0);

    // Backpressure: first code held for 3 stalled cycles
    send(4'b0110);
    drain(4'b0110, 3, 1'b0, 1'b0);

    // Gating: Enable low blocks acceptance
    Enable    = 1'b0;
    req_valid = 1'b1;
    req       = 4'b1000;
    #1;
    check("gate_req_ready", req_ready, 0);
    step();
    step();
    check("gate_no_capture", code_valid, 0);
    req_valid = 1'b0;
    Enable    = 1'b1;
    #1;

    // Enable dropped mid-emission: all codes still come out
    send(4'b1111);
    Enable = 1'b0;
    drain(4'b1111, 0, 1'b0, 1'b0);
    Enable = 1'b1;
    #1;

    // Full vector with competing request during emission, which must be ignored
    send(4'b1111);
    drain(4'b1111, 0, 1'b0, 1'b1);
    step();
    check("ignored_no_capture", code_valid, 0);

    // Zero vector
    send(4'b0000);
    drain(4'b0000, 0, 1'b0, 1'b0);
    step();
    check("zero_after_code_valid", code_valid, 0);
    check("zero_after_req_ready", req_ready, 1);

    // Asynchronous reset mid-emission
    send(4'b1011);
    code_ready = 1'b0;
    step();
    check("pre_rst_code_valid", code_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_code_valid", code_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_code", code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_code_valid", code_valid, 0);
    send(4'b0001);
    drain(4'b0001, 0, 1'b0, 1'b0);

    // Random vectors with random backpressure
    for (int n = 0; n < 40; n++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      send(v);
      drain(v, 0, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
